// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and a
// frame-length helper for the configurable transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } uart_tx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Oversampling ticks occupied by one complete frame.
   function automatic int uart_frame_ticks(input int dbit, input int os,
                                           input int par_en, input int stop_bits);
      return os * (1 + dbit + par_en + stop_bits);
   endfunction

endpackage

// File: rtl/mod_m_counter.sv
// Free-running modulo-M counter producing a one-clk max_tick pulse; used as
// the shared oversampling tick source for the UART.
module mod_m_counter #(
   parameter int M = 16
) (
   input  logic clk,
   input  logic reset_n,
   output logic max_tick
);

   localparam int CW = (M > 1) ? $clog2(M) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign max_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DBIT data bits, optional parity, one or two
// stop bits, zero-gap back-to-back frames and a line-break mode.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DBIT       = 8,
   parameter int OS         = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            s_tick,
   input  logic            tx_start,
   input  logic [DBIT-1:0] tx_din,
   input  logic            tx_break,
   output logic            tx_fifo_rd,
   output logic            tx_busy,
   output logic            tx
);

   localparam int TW = (OS > 1) ? $clog2(OS) : 1;
   localparam int BW = $clog2(DBIT);
   localparam logic [TW-1:0] TICK_LAST = TW'(OS - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic PAR_INIT = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
   localparam logic PAR_ON   = (PARITY_EN != 0);

   uart_tx_state_t  state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [BW-1:0]   bit_q, bit_d;
   logic [DBIT-1:0] shreg_q, shreg_d;
   logic            par_q, par_d;
   logic            tx_q, tx_d;
   logic            rd_q, rd_d;
   logic            tick_last;
   logic            load;

   assign tick_last = s_tick && (tick_q == TICK_LAST);

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      rd_d    = 1'b0;
      load    = 1'b0;

      // Bit timing only runs in the states that occupy a bit period.
      if (s_tick && (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}))
         tick_d = tick_last ? '0 : tick_q + TW'(1);

      case (state_q)
         ST_IDLE: begin
            if (tx_break)      state_d = ST_BREAK;
            else if (tx_start) load = 1'b1;
         end
         ST_START: begin
            if (tick_last) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (tick_last) begin
               par_d   = par_q ^ shreg_q[0];
               shreg_d = shreg_q >> 1;
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
                  state_d = PAR_ON ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (tick_last) begin
               bit_d   = '0;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick_last) begin
               if (bit_q == STOP_LAST) begin
                  bit_d = '0;
                  if (tx_start && !tx_break) load = 1'b1;
                  else                       state_d = ST_IDLE;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         ST_BREAK: begin
            // Leaving break always passes through a full stop period for mark time.
            if (!tx_break) begin
               tick_d  = '0;
               bit_d   = '0;
               state_d = ST_STOP;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         state_d = ST_START;
         shreg_d = tx_din;
         par_d   = PAR_INIT;
         tick_d  = '0;
         bit_d   = '0;
         rd_d    = 1'b1;
      end

      // The line is registered, so it is derived from the state being entered.
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shreg_d[0];
         ST_PARITY: tx_d = par_d;
         ST_BREAK:  tx_d = 1'b0;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         par_q   <= PAR_EVEN;
         tx_q    <= 1'b1;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         rd_q    <= rd_d;
      end
   end

   assign tx         = tx_q;
   assign tx_fifo_rd = rd_q;
   assign tx_busy    = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter: next generation of `uart_tx`, with configurable data width, optional even/odd parity, one or two stop bits, back-to-back frame streaming and a line-break mode. It sits between the TX FIFO and the `tx` pin. It consumes the shared oversampling tick `s_tick` from the existing `mod_m_counter` instance. It pops the FIFO through a one-cycle `tx_fifo_rd` strobe.

## Interface
- `DBIT`, 8: data bits per frame, legal 5..9.
- `OS`, 16: `s_tick` pulses per bit period, legal 4..64.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: when `PARITY_EN`=1, 0 selects even parity and 1 selects odd.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_tick`  in  1  one-`clk` oversampling pulse from `mod_m_counter`.
- `tx_start`  in  1  level: FIFO holds a word (not-empty).
- `tx_din`  in  DBIT  FIFO head word; bit 0 is transmitted first.
- `tx_break`  in  1  level: request a break (line held low).
- `tx_fifo_rd`  out  1  one-`clk` pop strobe.
- `tx_busy`  out  1  high whenever not in IDLE.
- `tx`  out  1  serial line, registered, idle high.

## Operation
- State machine states: IDLE, START, DATA, PARITY, STOP, BREAK.
- Internal counters:
  - `tick_cnt` counts `s_tick` pulses within the current bit, range 0..OS-1.
  - `bit_cnt` counts data bits (0..DBIT-1) and, in STOP, stop bits (0..STOP_BITS-1).
- IDLE:
  - `tx`=1, `busy`=0.
  - If `tx_break`=1, go to BREAK. Break has priority over `tx_start`.
  - Otherwise, if `tx_start`=1, go to START. On the same edge: load the shift register from `tx_din`, set the parity accumulator to `PARITY_ODD`, clear both counters, and assert `tx_fifo_rd` for exactly one cycle.
- START:
  - `tx`=0.
  - On the `s_tick` where `tick_cnt`=OS-1, go to DATA and clear `tick_cnt`.
- DATA:
  - `tx` = shift register bit 0.
  - At the end of each bit (`s_tick` with `tick_cnt`=OS-1): XOR the bit into the parity accumulator, shift right, increment `bit_cnt`.
  - After bit DBIT-1, go to PARITY if `PARITY_EN`=1, else STOP.
- PARITY:
  - `tx` = parity accumulator.
  - Go to STOP after OS ticks.
- STOP:
  - `tx`=1 for `STOP_BITS`×OS ticks.
  - At the end, if `tx_start`=1 and `tx_break`=0, go directly to START. This applies the same load and pop as from IDLE, with zero idle cycles between frames.
  - Otherwise go to IDLE.
- BREAK:
  - `tx`=0, `busy`=1.
  - Stays while `tx_break`=1.
  - When `tx_break` drops, go to STOP, which emits a full stop period so the line gets a mark time. Then return to IDLE or START as in STOP.
- `tx_break` asserted mid-frame has no effect until the frame's STOP completes.
- `tx_start` is ignored outside IDLE and the STOP exit.
- `tx_din` is sampled only on the pop edge. Later changes do not affect the frame in flight.
- Parity: even gives an even total count of 1s over data plus parity; odd gives an odd total.

## Timing
- Reset values while `reset_n`=0, applied asynchronously:
  - State IDLE.
  - `tx`=1, `tx_busy`=0, `tx_fifo_rd`=0.
  - Counters 0; shift register 0.
- Reset mid-frame aborts the frame and `tx` returns high immediately. No pop is issued at reset release.
- Latency from `tx_start` to the line: `tx_start` sampled high in IDLE on edge N gives `tx`=0, `tx_busy`=1 and `tx_fifo_rd`=1 after edge N. `tx_fifo_rd` is low again after edge N+1.
- Bit boundaries fall on the `clk` edge that samples an `s_tick` with `tick_cnt`=OS-1. Every bit lasts exactly OS ticks.
- Frame length in ticks = OS×(1 + DBIT + PARITY_EN + STOP_BITS).
- Back-to-back frames: the pop strobe is coincident with the STOP→START edge. The `busy` gap is 0 cycles.
- `tick_cnt` wraps OS-1→0. `bit_cnt` never exceeds DBIT-1. Counter widths are `$clog2(OS)` and `$clog2(DBIT)`.

## Structure
- Shared package `uart_pkg`:
  - state encoding enum `uart_tx_state_t`;
  - parity-mode constants `PAR_EVEN`=0, `PAR_ODD`=1;
  - localparam helper for the frame-tick count.
- No sub-module. The baud tick comes from the existing top-level `mod_m_counter`. The bench instantiates both blocks.

## Test plan
- Default parameters, `tx_din`=0x55, `tx_start` pulsed → `tx` runs 0,1,0,1,0,1,0,1,0 (start bit plus data LSB first), then 1 for 16 ticks. The frame is 160 ticks and the `tx_fifo_rd` pulse is exactly 1 cycle.
- `PARITY_EN`=1:
  - `PARITY_ODD`=0, `tx_din`=0x55 → parity bit 0.
  - `PARITY_ODD`=1, `tx_din`=0x03 → parity bit 1.
  - Frame is 176 ticks.
- `DBIT`=7, `STOP_BITS`=2, `tx_din`=0x7F → start bit, seven 1s, then 32 high ticks. Frame is 160 ticks.
- `tx_start` held high with words 0xA5 then 0x3C → two pops, second frame's start bit immediately after the first STOP, `tx_busy` never drops between frames.
- `reset_n` pulsed low during DATA bit 3 → `tx`=1 and `tx_busy`=0 asynchronously, no pop after release. A new `tx_start` gives a clean frame.
- `tx_break`=1 for 300 ticks in IDLE → `tx`=0 and `busy`=1 throughout, then 16 high ticks, then IDLE. `tx_start` held high throughout is not popped until after the stop period.
